// File: rtl/vga_ctrl_param.sv
// Parametrised VGA timing generator with a pixel read-ahead pipeline.
// Addresses are issued READ_LAT ce-cycles before the matching pixel data is
// sampled, so a frame buffer with that read latency lines up with the outputs.
module vga_ctrl_param #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COLOR_W  = 8,
    parameter int   READ_LAT = 1,
    parameter int   ADDR_W   = 10
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [3*COLOR_W-1:0] vga_data,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    h_addr,
    output logic [ADDR_W-1:0]    v_addr,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 valid,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 line_start,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VC_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    // Region bounds kept 32 bits wide so a zero back porch cannot overflow them.
    localparam logic [31:0] H_LAST = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_LAST = 32'(V_TOTAL - 1);
    localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);
    localparam logic [31:0] H_SS   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SE   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_SS   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SE   = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [HC_W-1:0] r_h_cnt;
    logic [VC_W-1:0] r_v_cnt;
    logic [31:0]     w_h32, w_v32;
    logic            w_act, w_hs_reg, w_vs_reg, w_ls, w_fs;
    // Pipeline word: {act, in_hsync, in_vsync, line_start, frame_start}
    logic [4:0]      w_cur, w_tap;

    assign w_h32    = 32'(r_h_cnt);
    assign w_v32    = 32'(r_v_cnt);
    assign w_act    = (w_h32 < H_ACT) && (w_v32 < V_ACT);
    assign w_hs_reg = (w_h32 >= H_SS) && (w_h32 < H_SE);
    assign w_vs_reg = (w_v32 >= V_SS) && (w_v32 < V_SE);
    assign w_ls     = w_act && (w_h32 == 32'd0);
    assign w_fs     = w_ls && (w_v32 == 32'd0);
    assign w_cur    = {w_act, w_hs_reg, w_vs_reg, w_ls, w_fs};

    assign rd_en  = ce & w_act;
    assign h_addr = w_act ? ADDR_W'(r_h_cnt) : '0;
    assign v_addr = w_act ? ADDR_W'(r_v_cnt) : '0;

    // Raster counters: h wraps at end of line and bumps v on the same ce.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (ce) begin
            if (w_h32 == H_LAST) begin
                r_h_cnt <= '0;
                if (w_v32 == V_LAST) r_v_cnt <= '0;
                else                 r_v_cnt <= r_v_cnt + VC_W'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HC_W'(1);
            end
        end
    end

    generate
        if (READ_LAT == 0) begin : g_nodly
            assign w_tap = w_cur;
        end else begin : g_dly
            logic [4:0] r_dly [READ_LAT];
            // Delay line matching the pixel source read latency.
            always_ff @(posedge pclk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < READ_LAT; i++) r_dly[i] <= '0;
                end else if (ce) begin
                    r_dly[0] <= w_cur;
                    for (int i = 1; i < READ_LAT; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_tap = r_dly[READ_LAT-1];
        end
    endgenerate

    // Output stage: samples pixel data and forces black outside the active area.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            valid       <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            valid                 <= w_tap[4];
            {vga_r, vga_g, vga_b} <= w_tap[4] ? vga_data : '0;
            hsync                 <= w_tap[3] ? HS_POL : ~HS_POL;
            vsync                 <= w_tap[2] ? VS_POL : ~VS_POL;
            line_start            <= w_tap[1];
            frame_start           <= w_tap[0];
        end
    end

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Bench for vga_ctrl_param: three instances (default mode, small mode with
// READ_LAT=2 fed by a pixel-source model, tiny mode with READ_LAT=0 and HS_POL=1)
// checked against a position-arithmetic model and a pixel scoreboard.
module tb_vga_ctrl_param;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        logic hp, vp;
    } mode_t;

    typedef struct {
        logic v, hs, vs, ls, fs;
        int   h, y;
    } exp_t;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: default mode, data held all-ones ----------------
    logic a_rst = 1'b0, a_ce = 1'b0;
    logic [23:0] a_data = 24'hFFFFFF;
    logic a_rd, a_hs, a_vs, a_vld, a_ls, a_fs;
    logic [9:0] a_ha, a_va;
    logic [7:0] a_r, a_g, a_b;

    vga_ctrl_param dut_a (
        .pclk(pclk), .reset(a_rst), .ce(a_ce), .vga_data(a_data),
        .rd_en(a_rd), .h_addr(a_ha), .v_addr(a_va), .hsync(a_hs), .vsync(a_vs),
        .valid(a_vld), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .line_start(a_ls), .frame_start(a_fs)
    );

    // ---------------- DUT B: small mode, READ_LAT=2 ----------------
    logic b_rst = 1'b0, b_ce = 1'b0;
    logic [23:0] b_data;
    logic b_rd, b_hs, b_vs, b_vld, b_ls, b_fs;
    logic [9:0] b_ha, b_va;
    logic [7:0] b_r, b_g, b_b;
    logic [15:0] b_s1, b_s2;

    vga_ctrl_param #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .READ_LAT(2)
    ) dut_b (
        .pclk(pclk), .reset(b_rst), .ce(b_ce), .vga_data(b_data),
        .rd_en(b_rd), .h_addr(b_ha), .v_addr(b_va), .hsync(b_hs), .vsync(b_vs),
        .valid(b_vld), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .line_start(b_ls), .frame_start(b_fs)
    );

    // Pixel source with two-cycle read latency returning its own coordinates.
    always_ff @(posedge pclk) begin
        if (b_ce) begin
            b_s1 <= {b_ha[7:0], b_va[7:0]};
            b_s2 <= b_s1;
        end
    end
    assign b_data = {b_s2[15:8], b_s2[7:0], ~b_s2[15:8]};

    // ---------------- DUT C: tiny mode, READ_LAT=0, HS_POL=1 ----------------
    logic c_rst = 1'b0, c_ce = 1'b0;
    logic [23:0] c_data = 24'h123456;
    logic c_rd, c_hs, c_vs, c_vld, c_ls, c_fs;
    logic [9:0] c_ha, c_va;
    logic [7:0] c_r, c_g, c_b;

    vga_ctrl_param #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .READ_LAT(0)
    ) dut_c (
        .pclk(pclk), .reset(c_rst), .ce(c_ce), .vga_data(c_data),
        .rd_en(c_rd), .h_addr(c_ha), .v_addr(c_va), .hsync(c_hs), .vsync(c_vs),
        .valid(c_vld), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
        .line_start(c_ls), .frame_start(c_fs)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected timing state for ce-position p (p<0: still in reset state).
    function automatic exp_t model(input mode_t m, input int p);
        exp_t e;
        int ht, vt;
        ht = m.ha + m.hf + m.hs + m.hb;
        vt = m.va + m.vf + m.vs + m.vb;
        e.v = 1'b0; e.hs = ~m.hp; e.vs = ~m.vp; e.ls = 1'b0; e.fs = 1'b0;
        e.h = 0; e.y = 0;
        if (p >= 0) begin
            e.h  = p % ht;
            e.y  = (p / ht) % vt;
            e.v  = (e.h < m.ha) && (e.y < m.va);
            e.hs = (e.h >= m.ha + m.hf && e.h < m.ha + m.hf + m.hs) ? m.hp : ~m.hp;
            e.vs = (e.y >= m.va + m.vf && e.y < m.va + m.vf + m.vs) ? m.vp : ~m.vp;
            e.ls = e.v && (e.h == 0);
            e.fs = e.ls && (e.y == 0);
        end
        return e;
    endfunction

    task automatic chk_out(input string n, input exp_t e, input logic vld, input logic hs,
                           input logic vs, input logic ls, input logic fs);
        chk({n, ".valid"}, vld, e.v);
        chk({n, ".hsync"}, hs, e.hs);
        chk({n, ".vsync"}, vs, e.vs);
        chk({n, ".line_start"}, ls, e.ls);
        chk({n, ".frame_start"}, fs, e.fs);
    endtask

    task automatic chk_addr(input string n, input exp_t e, input logic ce, input logic rd,
                            input logic [9:0] ha, input logic [9:0] va);
        chk({n, ".rd_en"}, rd, ce & e.v);
        chk({n, ".h_addr"}, ha, e.v ? 10'(e.h) : 10'd0);
        chk({n, ".v_addr"}, va, e.v ? 10'(e.y) : 10'd0);
    endtask

    initial begin
        mode_t mA, mB, mC;
        exp_t  e;
        logic [15:0] sb[$];
        logic [15:0] px;
        int a_last, c_last, b_run, b_lines, c_lines;
        logic b_seen, c_seen, a_ls_q, b_ls_q, b_fs_q, c_ls_q, c_fs_q;

        mA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        mB = '{16, 2, 3, 2, 6, 1, 2, 1, 1'b0, 1'b0};
        mC = '{4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0};
        a_last = -1; c_last = -1; b_run = 0; b_lines = 0; c_lines = 0;
        b_seen = 1'b0; c_seen = 1'b0;
        a_ls_q = 1'b0; b_ls_q = 1'b0; b_fs_q = 1'b0; c_ls_q = 1'b0; c_fs_q = 1'b0;

        // Reset state while held in reset.
        repeat (3) @(negedge pclk);
        chk_out("rstA", model(mA, -1), a_vld, a_hs, a_vs, a_ls, a_fs);
        chk("rstA.rgb", {a_r, a_g, a_b}, 24'h0);
        chk_out("rstB", model(mB, -1), b_vld, b_hs, b_vs, b_ls, b_fs);
        chk_out("rstC", model(mC, -1), c_vld, c_hs, c_vs, c_ls, c_fs);

        @(posedge pclk); #1;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_ce = 1'b1; b_ce = 1'b1; c_ce = 1'b1;

        // Free-running with ce=1: cycle k shows position k on the address side
        // and position k-(READ_LAT+1) on the outputs.
        for (int k = 0; k < 1700; k++) begin
            @(negedge pclk);
            // A
            chk_addr("A", model(mA, k), a_ce, a_rd, a_ha, a_va);
            e = model(mA, k - 2);
            chk_out("A", e, a_vld, a_hs, a_vs, a_ls, a_fs);
            chk("A.rgb", {a_r, a_g, a_b}, e.v ? 24'hFFFFFF : 24'h0);
            if (a_ls && !a_ls_q) begin
                if (a_last >= 0) chk("A.line_period", k - a_last, 800);
                a_last = k;
            end
            a_ls_q = a_ls;
            // B
            e = model(mB, k);
            chk_addr("B", e, b_ce, b_rd, b_ha, b_va);
            if (e.v) sb.push_back({8'(e.h), 8'(e.y)});
            e = model(mB, k - 3);
            chk_out("B", e, b_vld, b_hs, b_vs, b_ls, b_fs);
            if (b_vld === 1'b1) begin
                chk("B.sb_avail", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    px = sb.pop_front();
                    chk("B.pixel", {b_r, b_g, b_b}, {px[15:8], px[7:0], ~px[15:8]});
                end
                b_run++;
            end else begin
                chk("B.blank_rgb", {b_r, b_g, b_b}, 24'h0);
                if (b_run > 0) chk("B.run_len", b_run, 16);
                b_run = 0;
            end
            if (b_fs && !b_fs_q) begin
                if (b_seen) chk("B.lines_per_frame", b_lines, 6);
                b_seen = 1'b1;
                b_lines = 0;
            end
            if (b_ls && !b_ls_q) b_lines++;
            b_fs_q = b_fs; b_ls_q = b_ls;
            // C: 7 x 5 = 35 ce cycles per frame
            chk_addr("C", model(mC, k), c_ce, c_rd, c_ha, c_va);
            e = model(mC, k - 1);
            chk_out("C", e, c_vld, c_hs, c_vs, c_ls, c_fs);
            chk("C.rgb", {c_r, c_g, c_b}, e.v ? 24'h123456 : 24'h0);
            if (c_fs && !c_fs_q) begin
                if (c_seen) begin
                    chk("C.frame_period", k - c_last, 35);
                    chk("C.lines_per_frame", c_lines, 2);
                end
                c_seen = 1'b1;
                c_last = k;
                c_lines = 0;
            end
            if (c_ls && !c_ls_q) c_lines++;
            c_fs_q = c_fs; c_ls_q = c_ls;
        end

        // Asynchronous reset of A in mid-line, away from any clock edge.
        #2 a_rst = 1'b0;
        #1;
        chk_out("arstA", model(mA, -1), a_vld, a_hs, a_vs, a_ls, a_fs);
        chk("arstA.rgb", {a_r, a_g, a_b}, 24'h0);
        chk_addr("arstA", model(mA, 0), a_ce, a_rd, a_ha, a_va);

        // Restart with ce toggling 1/0: ce edges occur at the end of even cycles.
        @(posedge pclk); #1;
        a_rst = 1'b1;
        a_last = -1;
        a_ls_q = 1'b0;
        for (int j = 0; j < 3300; j++) begin
            int pos;
            a_ce = (j % 2 == 0);
            @(negedge pclk);
            pos = (j + 1) / 2;
            chk_addr("Ace", model(mA, pos), a_ce, a_rd, a_ha, a_va);
            e = model(mA, pos - 2);
            chk_out("Ace", e, a_vld, a_hs, a_vs, a_ls, a_fs);
            chk("Ace.rgb", {a_r, a_g, a_b}, e.v ? 24'hFFFFFF : 24'h0);
            if (a_ls && !a_ls_q) begin
                if (a_last >= 0) chk("Ace.line_period", j - a_last, 1600);
                a_last = j;
            end
            a_ls_q = a_ls;
            @(posedge pclk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
